// File: rtl/filt_capture_buf.sv
// filt_capture_buf
//   Sink for the sine filter's 18-bit output stream. An arm pulse starts a
//   capture: SKIP_N settling samples are dropped, then DEPTH consecutive
//   samples are written to an internal buffer while the signed peak max/min
//   are tracked. The completed capture is read back through a registered
//   read port.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears all state except the buffer
//   y_in       signed sample, one per clock
//   arm        single-cycle capture request (honoured in IDLE/DONE only)
//   capturing  high while samples are being written
//   done       high while a completed capture is held
//   rd_req     read strobe (serviced only while done)
//   rd_addr    buffer address to read
//   rd_data    registered signed read data
//   rd_valid   qualifies rd_data for one cycle
//   peak_max   signed maximum of captured samples
//   peak_min   signed minimum of captured samples
module filt_capture_buf #(
  parameter int WIDTH  = 18,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int SKIP_N = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  y_in,
  input  logic              arm,
  output logic              capturing,
  output logic              done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  peak_max,
  output logic [WIDTH-1:0]  peak_min
);

  localparam int SKIP_W = (SKIP_N > 1) ? $clog2(SKIP_N) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_N > 0) ? SKIP_N - 1 : 0);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [WIDTH-1:0]  PEAK_MAX_RST = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]  PEAK_MIN_RST = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_arm_ok;
  logic [SKIP_W-1:0]   r_skip_cnt;
  logic [ADDR_W-1:0]   r_wptr;
  logic                r_capturing;
  logic                r_done;
  logic [WIDTH-1:0]    r_rd_data;
  logic                r_rd_valid;
  logic [WIDTH-1:0]    r_peak_max;
  logic [WIDTH-1:0]    r_peak_min;
  logic [WIDTH-1:0]    r_mem [DEPTH];

  assign w_arm_ok = arm && ((r_state == IDLE) || (r_state == DONE));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (arm) w_next = (SKIP_N == 0) ? CAPTURE : SKIP;
      SKIP:       if (r_skip_cnt == SKIP_LAST) w_next = CAPTURE;
      CAPTURE:    if (r_wptr == ADDR_LAST) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_capturing <= 1'b0;
      r_done      <= 1'b0;
      r_skip_cnt  <= '0;
      r_wptr      <= '0;
      r_peak_max  <= PEAK_MAX_RST;
      r_peak_min  <= PEAK_MIN_RST;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      // Status flags track the state register exactly, one edge-aligned copy.
      r_capturing <= (w_next == CAPTURE);
      r_done      <= (w_next == DONE);

      if (w_arm_ok) begin
        r_skip_cnt <= '0;
        r_wptr     <= '0;
        r_peak_max <= PEAK_MAX_RST;
        r_peak_min <= PEAK_MIN_RST;
      end else if (r_state == SKIP) begin
        r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
      end else if (r_state == CAPTURE) begin
        r_wptr <= r_wptr + ADDR_W'(1);
        if ($signed(y_in) > $signed(r_peak_max)) r_peak_max <= y_in;
        if ($signed(y_in) < $signed(r_peak_min)) r_peak_min <= y_in;
      end

      // The read in an arm cycle still sees the old capture: the buffer is
      // only written once the FSM reaches CAPTURE.
      if (rd_req && (r_state == DONE)) begin
        r_rd_data  <= r_mem[rd_addr];
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == CAPTURE) r_mem[r_wptr] <= y_in;
  end

  assign capturing = r_capturing;
  assign done      = r_done;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign peak_max  = r_peak_max;
  assign peak_min  = r_peak_min;

endmodule

// File: tb/tb_filt_capture_buf.sv
module tb_filt_capture_buf;
  localparam int W  = 18;
  localparam int D  = 64;
  localparam int SK = 16;
  localparam int HN = 4096;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] y_in = '0;
  logic         arm = 1'b0;
  logic         rd_req = 1'b0;
  logic [5:0]   rd_addr = '0;
  logic         capturing, done, rd_valid;
  logic [W-1:0] rd_data, peak_max, peak_min;
  logic         capturing0, done0, rd_valid0;
  logic [W-1:0] rd_data0, peak_max0, peak_min0;

  always #5 clk = ~clk;

  filt_capture_buf #(.WIDTH(W), .DEPTH(D), .ADDR_W(6), .SKIP_N(SK)) dut (
    .clk(clk), .reset(reset), .y_in(y_in), .arm(arm),
    .capturing(capturing), .done(done), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .peak_max(peak_max), .peak_min(peak_min));

  filt_capture_buf #(.WIDTH(W), .DEPTH(D), .ADDR_W(6), .SKIP_N(0)) dut0 (
    .clk(clk), .reset(reset), .y_in(y_in), .arm(arm),
    .capturing(capturing0), .done(done0), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .peak_max(peak_max0), .peak_min(peak_min0));

  // Reference model: every sample presented at edge e is kept in hist[e];
  // a capture armed at edge ta holds hist[ta+SK+1+a] at address a.
  int hist [HN];
  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int ymode  = 0;  // 0 constant, 1 ramp, 2 random

  typedef struct {
    logic [5:0] addr;
    int         exp;
  } rvec_t;
  rvec_t tbl [6];

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int h(input int i);
    return hist[i % HN];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc - 1);
    end
  endtask

  task automatic tick();
    hist[cyc % HN] = sx(y_in);
    @(posedge clk);
    #1;
    cyc++;
    case (ymode)
      1: y_in = y_in + 18'd1;
      2: y_in = 18'($urandom);
      default: ;
    endcase
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " capturing"}, int'(capturing), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " rd_valid"}, int'(rd_valid), 0);
    chk({tag, " rd_data"}, sx(rd_data), 0);
    chk({tag, " peak_max"}, sx(peak_max), -131072);
    chk({tag, " peak_min"}, sx(peak_min), 131071);
  endtask

  // Runs from the edge after the arm edge ta up to the final write edge,
  // checking the status flags against the capture timeline.
  task automatic run_capture(input int ta, input bit extra_arms);
    int e;
    for (int n = 0; n < SK + D; n++) begin
      arm = extra_arms && ((cyc == ta + 5) || (cyc == ta + SK + 1 + 10));
      tick();
      arm = 1'b0;
      e = cyc - 1;
      chk("capturing", int'(capturing), int'((e >= ta + SK) && (e < ta + SK + D)));
      chk("done", int'(done), int'(e >= ta + SK + D));
    end
  endtask

  task automatic read_all(input int ta, input bit shuffle);
    int a;
    rd_req = 1'b1;
    for (int k = 0; k < D; k++) begin
      a = shuffle ? int'($urandom_range(0, D - 1)) : k;
      rd_addr = 6'(a);
      tick();
      chk("rd_valid", int'(rd_valid), 1);
      chk("rd_data", sx(rd_data), h(ta + SK + 1 + a));
    end
    rd_req = 1'b0;
    tick();
    chk("rd_valid idle", int'(rd_valid), 0);
  endtask

  task automatic check_peaks(input int ta);
    int mx, mn, v;
    mx = h(ta + SK + 1);
    mn = mx;
    for (int k = 1; k < D; k++) begin
      v = h(ta + SK + 1 + k);
      if (v > mx) mx = v;
      if (v < mn) mn = v;
    end
    chk("peak_max", sx(peak_max), mx);
    chk("peak_min", sx(peak_min), mn);
  endtask

  task automatic arm_now(output int ta);
    arm = 1'b1;
    ta = cyc;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    int ta, t0;
    tbl[0] = '{6'd0, 117};
    tbl[1] = '{6'd63, 180};
    tbl[2] = '{6'd5, 122};
    tbl[3] = '{6'd31, 148};
    tbl[4] = '{6'd62, 179};
    tbl[5] = '{6'd1, 118};

    // Reset held for 21 cycles with random input
    ymode = 2;
    #1 reset = 1'b1;
    #1 chk_reset_vals("rst async");
    repeat (21) tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    // SKIP_N=0 instance: ramp, arm where y_in=50
    ymode = 1;
    y_in = 18'd45;
    repeat (5) tick();
    arm_now(t0);
    chk("cap0 after arm", int'(capturing0), 1);
    for (int n = 0; n < 80; n++) begin
      tick();
      chk("done0", int'(done0), int'((cyc - 1) >= t0 + 64));
      chk("capturing0", int'(capturing0), int'((cyc - 1) < t0 + 64));
    end
    rd_req = 1'b1;
    rd_addr = 6'd0;
    tick();
    chk("skip0 buf0", sx(rd_data0), 51);
    rd_addr = 6'd63;
    tick();
    chk("skip0 buf63", sx(rd_data0), 114);
    rd_req = 1'b0;

    // Ramp capture with default settling, arm where y_in=100
    y_in = 18'd90;
    repeat (10) tick();
    arm_now(ta);
    chk("arm peak_max", sx(peak_max), -131072);
    chk("arm peak_min", sx(peak_min), 131071);
    run_capture(ta, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rd_req = 1'b1;
      rd_addr = tbl[i].addr;
      tick();
      chk("tbl rd_valid", int'(rd_valid), 1);
      chk("tbl rd_data", sx(rd_data), tbl[i].exp);
    end
    read_all(ta, 1'b0);
    chk("ramp peak_max", sx(peak_max), 180);
    chk("ramp peak_min", sx(peak_min), 117);

    // Re-arm from DONE with a same-cycle read of the old capture
    ymode = 2;
    arm = 1'b1;
    rd_req = 1'b1;
    rd_addr = 6'd5;
    ta = cyc;
    tick();
    arm = 1'b0;
    rd_req = 1'b0;
    chk("rearm rd_valid", int'(rd_valid), 1);
    chk("rearm old buf5", sx(rd_data), 122);
    chk("rearm done", int'(done), 0);
    chk("rearm peak_max", sx(peak_max), -131072);
    chk("rearm peak_min", sx(peak_min), 131071);
    run_capture(ta, 1'b1);
    read_all(ta, 1'b1);
    check_peaks(ta);

    // Most negative constant input
    ymode = 0;
    y_in = 18'h20000;
    tick();
    arm_now(ta);
    run_capture(ta, 1'b0);
    read_all(ta, 1'b1);
    chk("neg peak_max", sx(peak_max), -131072);
    chk("neg peak_min", sx(peak_min), -131072);

    // Random captures with random gaps
    ymode = 2;
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 4)) tick();
      arm_now(ta);
      run_capture(ta, 1'b0);
      read_all(ta, 1'b1);
      check_peaks(ta);
    end

    // Reset asserted between edges while address 30 is being written
    arm_now(ta);
    while (cyc - 1 < ta + SK + 1 + 30) tick();
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    tick();
    reset = 1'b0;
    rd_req = 1'b1;
    for (int n = 0; n < 10; n++) begin
      rd_addr = 6'($urandom);
      tick();
      chk("post-rst capturing", int'(capturing), 0);
      chk("post-rst done", int'(done), 0);
      chk("post-rst rd_valid", int'(rd_valid), 0);
      chk("post-rst rd_data", sx(rd_data), 0);
    end
    rd_req = 1'b0;
    arm_now(ta);
    run_capture(ta, 1'b0);
    read_all(ta, 1'b1);
    check_peaks(ta);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
